// File: rtl/stage_4.sv
// Memory-access stage: issues req/ack data-memory transactions, formats load/store
// lanes and registers the write-back bundle. Optional MISALIGN_TRAP_EN traps misaligned accesses.
module stage_4 #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [31:0]       i_alu_out,
    input  logic [31:0]       i_rs_2,
    input  logic [4:0]        i_rd_num,
    input  logic [6:0]        i_opcode,
    input  logic [2:0]        i_func_3,
    input  logic              i_op_type,
    output logic              o_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              o_valid,
    output logic [4:0]        o_rd_num,
    output logic [31:0]       o_wb_data,
    output logic              o_wb_en,
    output logic              o_exc
);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] MEM       = 1'b1;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    logic [0:0]        state_r;
    logic              req_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [3:0]        wstrb_r;
    logic [4:0]        rd_r;
    logic [2:0]        func3_r;
    logic [1:0]        ofs_r;
    logic              valid_r;
    logic [4:0]        rd_out_r;
    logic [31:0]       wb_data_r;
    logic              wb_en_r;
    logic              exc_r;

    logic [1:0]        offset_s;
    logic              is_store_s;
    logic [31:0]       wdata_s;
    logic [3:0]        wstrb_s;
    logic              misalign_s;
    logic              alu_wb_en_s;

    // Load lane extraction: byte by full offset, halfword by offset bit 1, else whole word.
    function automatic logic [31:0] load_fmt_f(input logic [31:0] rdata,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  ofs);
        logic [7:0]  b;
        logic [15:0] h;
        case (ofs)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            2'd3:    b = rdata[31:24];
            default: b = rdata[7:0];
        endcase
        h = ofs[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  load_fmt_f = {{24{b[7]}}, b};
            3'b100:  load_fmt_f = {24'd0, b};
            3'b001:  load_fmt_f = {{16{h[15]}}, h};
            3'b101:  load_fmt_f = {16'd0, h};
            default: load_fmt_f = rdata;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic misaligned_f(input logic [2:0] f3, input logic st,
                                          input logic [1:0] a);
        logic byte_acc;
        logic half_acc;
        byte_acc = st ? (f3 == 3'b000) : (f3 == 3'b000 || f3 == 3'b100);
        half_acc = st ? (f3 == 3'b001) : (f3 == 3'b001 || f3 == 3'b101);
        if (byte_acc) begin
            misaligned_f = 1'b0;
        end else if (half_acc) begin
            misaligned_f = a[0];
        end else begin
            misaligned_f = (a != 2'b00);
        end
    endfunction
`endif

    assign offset_s    = i_alu_out[1:0];
    assign is_store_s  = (i_opcode == OP_STORE);
    assign alu_wb_en_s = (i_rd_num != 5'd0) && (i_opcode != OP_BRANCH) && (i_opcode != OP_STORE);

`ifdef MISALIGN_TRAP_EN
    assign misalign_s = misaligned_f(i_func_3, is_store_s, offset_s);
`else
    assign misalign_s = 1'b0;
`endif

    // Store lane replication and byte strobes; loads never assert strobes.
    always_comb begin
        wdata_s = i_rs_2;
        wstrb_s = 4'b1111;
        case (i_func_3)
            3'b000: begin
                wdata_s = {4{i_rs_2[7:0]}};
                wstrb_s = 4'b0001 << offset_s;
            end
            3'b001: begin
                wdata_s = {2{i_rs_2[15:0]}};
                wstrb_s = 4'b0011 << {offset_s[1], 1'b0};
            end
            default: begin
                wdata_s = i_rs_2;
                wstrb_s = 4'b1111;
            end
        endcase
        if (!is_store_s) begin
            wstrb_s = 4'b0000;
        end else begin
            wstrb_s = wstrb_s;
        end
    end

    // Stage FSM, memory port registers and write-back bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= 32'd0;
            wstrb_r   <= 4'd0;
            rd_r      <= 5'd0;
            func3_r   <= 3'd0;
            ofs_r     <= 2'd0;
            valid_r   <= 1'b0;
            rd_out_r  <= 5'd0;
            wb_data_r <= 32'd0;
            wb_en_r   <= 1'b0;
            exc_r     <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            wb_en_r <= 1'b0;
            exc_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_valid && !i_op_type) begin
                        valid_r   <= 1'b1;
                        wb_data_r <= i_alu_out;
                        rd_out_r  <= i_rd_num;
                        wb_en_r   <= alu_wb_en_s;
                    end else if (i_valid && misalign_s) begin
                        valid_r   <= 1'b1;
                        exc_r     <= 1'b1;
                        wb_data_r <= i_alu_out;
                        rd_out_r  <= i_rd_num;
                    end else if (i_valid) begin
                        state_r <= MEM;
                        req_r   <= 1'b1;
                        we_r    <= is_store_s;
                        addr_r  <= {i_alu_out[ADDR_W-1:2], 2'b00};
                        wdata_r <= wdata_s;
                        wstrb_r <= wstrb_s;
                        rd_r    <= i_rd_num;
                        func3_r <= i_func_3;
                        ofs_r   <= offset_s;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        state_r  <= IDLE;
                        req_r    <= 1'b0;
                        we_r     <= 1'b0;
                        valid_r  <= 1'b1;
                        rd_out_r <= rd_r;
                        if (we_r) begin
                            wb_en_r <= 1'b0;
                        end else begin
                            wb_en_r   <= (rd_r != 5'd0);
                            wb_data_r <= load_fmt_f(mem_rdata, func3_r, ofs_r);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign o_stall   = (state_r == MEM);
    assign mem_req   = req_r;
    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign mem_wstrb = wstrb_r;
    assign o_valid   = valid_r;
    assign o_rd_num  = rd_out_r;
    assign o_wb_data = wb_data_r;
    assign o_wb_en   = wb_en_r;
    assign o_exc     = exc_r;

endmodule

// File: tb/tb_stage_4.sv
// Scoreboard bench for stage_4: expected retire bundles are queued at issue and
// compared when o_valid pulses; memory-port fields are checked during each transaction.
module tb_stage_4;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_alu_out = 32'd0;
    logic [31:0] i_rs_2 = 32'd0;
    logic [4:0]  i_rd_num = 5'd0;
    logic [6:0]  i_opcode = 7'd0;
    logic [2:0]  i_func_3 = 3'd0;
    logic        i_op_type = 1'b0;
    logic        o_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        o_valid;
    logic [4:0]  o_rd_num;
    logic [31:0] o_wb_data;
    logic        o_wb_en;
    logic        o_exc;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wb_en;
        logic        exc;
        logic        chk_data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    stage_4 #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_alu_out(i_alu_out),
        .i_rs_2(i_rs_2), .i_rd_num(i_rd_num), .i_opcode(i_opcode), .i_func_3(i_func_3),
        .i_op_type(i_op_type), .o_stall(o_stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .o_valid(o_valid), .o_rd_num(o_rd_num),
        .o_wb_data(o_wb_data), .o_wb_en(o_wb_en), .o_exc(o_exc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Retire monitor: every o_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_valid", {31'd0, o_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("rd_num", {27'd0, o_rd_num}, {27'd0, e.rd});
                check_eq("wb_en", {31'd0, o_wb_en}, {31'd0, e.wb_en});
                check_eq("exc", {31'd0, o_exc}, {31'd0, e.exc});
                if (e.chk_data) check_eq("wb_data", o_wb_data, e.data);
            end
        end
    end

    // Called at a negedge; presents one ALU instruction for a single cycle.
    task automatic alu_op(input logic [4:0] rd, input logic [31:0] data,
                          input logic [6:0] opc, input logic exp_wb);
        i_valid = 1'b1; i_op_type = 1'b0; i_opcode = opc; i_func_3 = 3'd0;
        i_alu_out = data; i_rd_num = rd;
        sb_q.push_back('{rd, data, exp_wb, 1'b0, 1'b1});
        check_eq("alu_stall", {31'd0, o_stall}, 32'd0);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    // Called at a negedge; runs one load/store with a fixed number of wait cycles.
    task automatic mem_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [4:0] rd,
                          input logic [31:0] rdata, input int waits,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_wstrb, input logic [31:0] exp_data,
                          input logic exp_wb);
        int stall_cnt;
        i_valid = 1'b1; i_op_type = 1'b1; i_opcode = st ? OP_STORE : OP_LOAD;
        i_func_3 = f3; i_alu_out = addr; i_rs_2 = rs2; i_rd_num = rd;
        sb_q.push_back('{rd, exp_data, exp_wb, 1'b0, !st});
        stall_cnt = 0;
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            i_valid = 1'b0;
            check_eq("mem_req_held", {31'd0, mem_req}, 32'd1);
            check_eq("valid_in_mem", {31'd0, o_valid}, 32'd0);
            stall_cnt += int'(o_stall);
            if (i == 0) begin
                check_eq("mem_addr", mem_addr, exp_addr);
                check_eq("mem_we", {31'd0, mem_we}, {31'd0, st});
                check_eq("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
                if (st) check_eq("mem_wdata", mem_wdata, exp_wdata);
            end
            if (i == waits) begin
                mem_ack = 1'b1;
                mem_rdata = rdata;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
        check_eq("stall_cycles", stall_cnt, waits + 1);
        check_eq("stall_after", {31'd0, o_stall}, 32'd0);
        check_eq("req_after", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
        check_eq("rst_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_wb_data", o_wb_data, 32'd0);
        check_eq("rst_stall", {31'd0, o_stall}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        alu_op(5'd5, 32'h0000_1234, OP_ALU, 1'b1);
        alu_op(5'd6, 32'hA5A5_0001, OP_ALU, 1'b1);
        alu_op(5'd0, 32'h0000_0077, OP_ALU, 1'b0);
        alu_op(5'd7, 32'h0000_0040, OP_BRANCH, 1'b0);
        @(negedge clk);

        mem_op(1'b0, 3'b000, 32'h0000_0103, 32'd0, 5'd8, 32'h80FF_FF00, 3,
               32'h0000_0100, 32'd0, 4'b0000, 32'hFFFF_FF80, 1'b1);
        mem_op(1'b0, 3'b100, 32'h0000_0103, 32'd0, 5'd8, 32'h80FF_FF00, 3,
               32'h0000_0100, 32'd0, 4'b0000, 32'h0000_0080, 1'b1);
        mem_op(1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 5'd2, 32'd0, 1,
               32'h0000_0200, 32'hBEEF_BEEF, 4'b1100, 32'd0, 1'b0);
        mem_op(1'b1, 3'b000, 32'h0000_0201, 32'h1234_56A5, 5'd2, 32'd0, 0,
               32'h0000_0200, 32'hA5A5_A5A5, 4'b0010, 32'd0, 1'b0);
        mem_op(1'b1, 3'b010, 32'h0000_0208, 32'h0BAD_F00D, 5'd2, 32'd0, 2,
               32'h0000_0208, 32'h0BAD_F00D, 4'b1111, 32'd0, 1'b0);
        mem_op(1'b0, 3'b001, 32'h0000_0302, 32'd0, 5'd4, 32'h8001_7FFF, 1,
               32'h0000_0300, 32'd0, 4'b0000, 32'hFFFF_8001, 1'b1);
        mem_op(1'b0, 3'b101, 32'h0000_0300, 32'd0, 5'd4, 32'h8001_7FFF, 0,
               32'h0000_0300, 32'd0, 4'b0000, 32'h0000_7FFF, 1'b1);
        mem_op(1'b0, 3'b000, 32'h0000_0101, 32'd0, 5'd9, 32'h0000_7F00, 0,
               32'h0000_0100, 32'd0, 4'b0000, 32'h0000_007F, 1'b1);
        mem_op(1'b0, 3'b010, 32'h0000_0400, 32'd0, 5'd0, 32'h1234_5678, 2,
               32'h0000_0400, 32'd0, 4'b0000, 32'h1234_5678, 1'b0);
        alu_op(5'd3, 32'hCAFE_0003, OP_ALU, 1'b1);

`ifdef MISALIGN_TRAP_EN
        i_valid = 1'b1; i_op_type = 1'b1; i_opcode = OP_LOAD; i_func_3 = 3'b010;
        i_alu_out = 32'h0000_0101; i_rd_num = 5'd9;
        sb_q.push_back('{5'd9, 32'd0, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        i_valid = 1'b0;
        check_eq("trap_no_req", {31'd0, mem_req}, 32'd0);
        check_eq("trap_no_stall", {31'd0, o_stall}, 32'd0);
        @(negedge clk);
`else
        mem_op(1'b0, 3'b010, 32'h0000_0101, 32'd0, 5'd9, 32'hCAFE_F00D, 1,
               32'h0000_0100, 32'd0, 4'b0000, 32'hCAFE_F00D, 1'b1);
`endif

        // Abandon a pending load with an asynchronous reset, then send a stray ack.
        i_valid = 1'b1; i_op_type = 1'b1; i_opcode = OP_LOAD; i_func_3 = 3'b010;
        i_alu_out = 32'h0000_0500; i_rd_num = 5'd3;
        @(negedge clk);
        i_valid = 1'b0;
        check_eq("pre_rst_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check_eq("mid_rst_stall", {31'd0, o_stall}, 32'd0);
        check_eq("mid_rst_addr", mem_addr, 32'd0);
        check_eq("mid_rst_wb_data", o_wb_data, 32'd0);
        check_eq("mid_rst_rd", {27'd0, o_rd_num}, 32'd0);
        check_eq("mid_rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        check_eq("stray_ack_valid", {31'd0, o_valid}, 32'd0);
        check_eq("stray_ack_req", {31'd0, mem_req}, 32'd0);
        check_eq("stray_ack_stall", {31'd0, o_stall}, 32'd0);

        alu_op(5'd11, 32'h0000_BEEF, OP_ALU, 1'b1);
        @(negedge clk);
        check_eq("sb_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_4.md
Name: stage_4

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline. Sits directly downstream of the execute stage and upstream of write-back.
- Consumes the execute results: ALU result/effective address, rs_2 store data, rd number, opcode, func_3 and op_type.
- Drives a req/ack data-memory port. Formats load data and store strobes, and presents a registered write-back bundle.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- ADDR_W, 32, width of mem_addr; effective address truncated to ADDR_W bits.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  execute stage presents an instruction
- i_alu_out  in  32  ALU result / effective address
- i_rs_2  in  32  store data
- i_rd_num  in  5  destination register
- i_opcode  in  7  instruction opcode
- i_func_3  in  3  width/sign selector
- i_op_type  in  1  1 = load/store, 0 = ALU/jump
- o_stall  out  1  hold execute stage and upstream
- mem_req  out  1  data-memory request
- mem_we  out  1  1 = store
- mem_addr  out  ADDR_W  word-aligned address
- mem_wdata  out  32  store data, lane-replicated
- mem_wstrb  out  4  byte enables
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  32  read word, valid with mem_ack
- o_valid  out  1  write-back bundle valid
- o_rd_num  out  5  destination register
- o_wb_data  out  32  write-back value
- o_wb_en  out  1  register-file write enable
- o_exc  out  1  misaligned-access exception (see Optional Feature)

Behaviour:
- Reset (async, rst_n low): state IDLE; o_valid, o_wb_en, o_exc, mem_req, mem_we = 0; o_rd_num, o_wb_data, mem_addr, mem_wdata, mem_wstrb = 0.
- Reset asserted mid-transaction:
  - mem_req drops immediately and the transaction is abandoned.
  - A late mem_ack after reset release is ignored in IDLE.
- FSM states: IDLE, MEM.
- IDLE with i_valid=1 and i_op_type=0:
  - Next edge: o_valid=1, o_wb_data=i_alu_out, o_rd_num=i_rd_num.
  - o_wb_en=1 unless rd=0 or opcode is BRANCH (1100011) or STORE (0100011).
  - Latency 1 cycle; back-to-back accepts allowed.
- IDLE with i_valid=1 and i_op_type=1:
  - Capture address, rs_2, rd, func_3, and load/store flag.
  - Go to MEM; o_valid=0 next cycle.
- MEM state:
  - mem_req=1, driven from registered fields; held stable until mem_ack.
  - o_stall=1 for all of MEM, including the ack cycle.
- MEM with mem_ack=1: at that edge, load the output register, set o_valid=1, return to IDLE. Next instruction is accepted the cycle after.
- o_valid is a one-cycle pulse per retired instruction. o_valid=0 in any cycle with nothing retired.
- mem_addr = {addr[ADDR_W-1:2], 2'b00}. mem_we=1 for store.
- Store func_3 and data/strobes (addr offset a=addr[1:0]):
  - 000 SB: wdata = byte replicated x4; wstrb = 0001<<a.
  - 001 SH: wdata = halfword replicated x2; wstrb = 0011<<{a[1],0}.
  - 010 SW: wdata = i_rs_2; wstrb = 1111.
  - Reserved store func_3 treated as SW.
- Loads: wstrb=0000. Select the byte/half by the address offset.
  - 000 LB: sign-extend.
  - 100 LBU: zero-extend.
  - 001 LH: sign-extend.
  - 101 LHU: zero-extend.
  - 010 LW: full word.
  - Reserved load func_3 (011, 110, 111) treated as LW.
- Write enables on retire:
  - Load: o_wb_en = (rd != 0).
  - Store: o_wb_en=0, o_valid=1.
- mem_ack seen in IDLE: ignored.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: misaligned access (LW/SW with a!=0; LH/LHU/SH with a[0]=1) raises no mem_req and skips MEM. Next edge: o_valid=1, o_exc=1, o_wb_en=0.
- Undefined:
  - o_exc is tied 0.
  - Word accesses ignore a.
  - Halfword accesses use a[1] only.
  - All accesses proceed through MEM.

Test Plan:
- ALU op alu_out=0x0000_1234, rd=5, op_type=0 -> next cycle o_valid=1, o_wb_data=0x1234, o_wb_en=1, o_stall never high.
- LB addr=0x103, mem_rdata=0x80FF_FF00 acked after 3 wait cycles -> mem_addr=0x100, o_stall high 4 cycles, o_wb_data=0xFFFF_FF80. Repeat as LBU -> 0x0000_0080.
- SH addr=0x202, rs_2=0xDEAD_BEEF -> mem_we=1, mem_wdata=0xBEEF_BEEF, mem_wstrb=1100; retire with o_wb_en=0.
- ALU op with rd=0, and BRANCH opcode with rd=7 -> o_valid=1, o_wb_en=0 in both cases.
- LW pending in MEM, rst_n pulsed low -> mem_req=0 immediately, all outputs 0; stray mem_ack after release ignored.
- With MISALIGN_TRAP_EN, LW addr=0x101 -> no mem_req, next cycle o_valid=1, o_exc=1. Without it -> mem_addr=0x100, normal LW retire.
